// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding-select and load-use interlock unit
// tracking in-flight register writes across DEPTH post-decode stages.
module hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int NRS        = 2,
  parameter int RA_W       = 5,
  parameter int ALU_AVAIL  = 1,
  parameter int LOAD_AVAIL = 2,
  parameter int KILL_DEPTH = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic                 dec_we,
  input  logic                 dec_is_load,
  input  logic [RA_W-1:0]      dec_rd,
  input  logic [NRS*RA_W-1:0]  dec_rs,
  input  logic [NRS-1:0]       dec_rs_used,
  input  logic                 ext_stall,
  input  logic                 flush,
  output logic [NRS*SEL_W-1:0] fwd_sel,
  output logic                 hazard_stall,
  output logic                 retire_valid,
  output logic [RA_W-1:0]      retire_rd,
  output logic [CNT_W-1:0]     stall_count
);

  typedef struct packed {
    logic            v;
    logic            we;
    logic            ld;
    logic [RA_W-1:0] rd;
  } ent_t;

  ent_t ent [1:DEPTH];
  ent_t dec_ent;
  logic haz;
  logic insert;

  assign dec_ent = '{v: 1'b1, we: dec_we, ld: dec_is_load, rd: dec_rd};

  // youngest matching stage decides; an unready one stalls, never falls back
  always_comb begin
    logic hit;
    fwd_sel = '0;
    haz     = 1'b0;
    hit     = 1'b0;
    for (int i = 0; i < NRS; i++) begin
      hit = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (!hit && dec_valid && dec_rs_used[i] &&
            dec_rs[i*RA_W +: RA_W] != '0 &&
            ent[k].v && ent[k].we &&
            ent[k].rd == dec_rs[i*RA_W +: RA_W]) begin
          hit = 1'b1;
          if (k >= (ent[k].ld ? LOAD_AVAIL : ALU_AVAIL))
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
          else
            haz = 1'b1;
        end
      end
    end
  end

  assign hazard_stall = haz & ~flush;
  assign insert       = dec_valid & ~hazard_stall & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= DEPTH; k++)
        ent[k] <= '0;
      stall_count <= '0;
    end else if (ext_stall) begin
      if (flush)
        for (int k = 1; k <= KILL_DEPTH; k++)
          ent[k].v <= 1'b0;
    end else begin
      for (int k = 2; k <= DEPTH; k++)
        ent[k] <= ent[k-1];
      ent[1] <= insert ? dec_ent : '0;
      // killed entries still travel down, just invalidated
      if (flush)
        for (int k = 1; k <= KILL_DEPTH; k++)
          ent[k+1].v <= 1'b0;
      if (hazard_stall && !(&stall_count))
        stall_count <= stall_count + 1'b1;
    end
  end

  assign retire_valid = ent[DEPTH].v & ent[DEPTH].we;
  assign retire_rd    = ent[DEPTH].rd;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed plus random stimulus against a
// behavioural pipeline model of hazard_scoreboard.
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int NRS   = 2;
  localparam int RA_W  = 5;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;
  localparam int ALU_A = 1;
  localparam int LD_A  = 2;
  localparam int KILL  = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 dec_valid, dec_we, dec_is_load;
  logic [RA_W-1:0]      dec_rd;
  logic [NRS*RA_W-1:0]  dec_rs;
  logic [NRS-1:0]       dec_rs_used;
  logic                 ext_stall, flush;
  logic [NRS*SEL_W-1:0] fwd_sel;
  logic                 hazard_stall, retire_valid;
  logic [RA_W-1:0]      retire_rd;
  logic [CNT_W-1:0]     stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n),
    .dec_valid(dec_valid), .dec_we(dec_we),
    .dec_is_load(dec_is_load), .dec_rd(dec_rd),
    .dec_rs(dec_rs), .dec_rs_used(dec_rs_used),
    .ext_stall(ext_stall), .flush(flush),
    .fwd_sel(fwd_sel), .hazard_stall(hazard_stall),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .stall_count(stall_count)
  );

  typedef struct {
    bit       v;
    bit       we;
    bit       ld;
    bit [4:0] rd;
  } op_t;

  // pipe[0] is stage 1 (X), pipe[DEPTH-1] is writeback
  op_t pipe [DEPTH];
  int  m_cnt = 0;

  initial for (int k = 0; k < DEPTH; k++) pipe[k] = '{0, 0, 0, 0};

  function automatic void model_eval(output logic [NRS*SEL_W-1:0] sel,
                                     output logic haz);
    int rs;
    sel = '0;
    haz = 1'b0;
    for (int i = 0; i < NRS; i++) begin
      rs = int'(dec_rs[i*RA_W +: RA_W]);
      if (dec_valid && dec_rs_used[i] && rs != 0) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (pipe[k-1].v && pipe[k-1].we && int'(pipe[k-1].rd) == rs) begin
            if (k >= (pipe[k-1].ld ? LD_A : ALU_A))
              sel[i*SEL_W +: SEL_W] = SEL_W'(k);
            else
              haz = 1'b1;
            break;
          end
        end
      end
    end
    if (flush) haz = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [NRS*SEL_W-1:0] s;
    logic h;
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] = '{0, 0, 0, 0};
      m_cnt = 0;
    end else begin
      model_eval(s, h);
      if (ext_stall) begin
        if (flush)
          for (int k = 0; k < KILL; k++) pipe[k].v = 0;
      end else begin
        if (h && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (flush)
          for (int k = 0; k < KILL; k++) pipe[k].v = 0;
        for (int k = DEPTH - 1; k > 0; k--) pipe[k] = pipe[k-1];
        if (dec_valid && !h && !flush)
          pipe[0] = '{1, dec_we, dec_is_load, dec_rd};
        else
          pipe[0] = '{0, 0, 0, 0};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model comparison every cycle, away from the rising edge
  always @(negedge clk) begin
    logic [NRS*SEL_W-1:0] es;
    logic eh, erv;
    #2;
    model_eval(es, eh);
    erv = pipe[DEPTH-1].v & pipe[DEPTH-1].we;
    chk("m_fwd_sel", 32'(fwd_sel), 32'(es));
    chk("m_hazard", 32'(hazard_stall), 32'(eh));
    chk("m_retire_valid", 32'(retire_valid), 32'(erv));
    if (erv) chk("m_retire_rd", 32'(retire_rd), 32'(pipe[DEPTH-1].rd));
    chk("m_stall_count", 32'(stall_count), 32'(m_cnt));
  end

  task automatic cyc(input logic v, we, ld, input logic [4:0] rd,
                     input logic [4:0] rs0, rs1, input logic [1:0] used,
                     input logic es, fl);
    @(negedge clk);
    dec_valid = v; dec_we = we; dec_is_load = ld; dec_rd = rd;
    dec_rs = {rs1, rs0}; dec_rs_used = used;
    ext_stall = es; flush = fl;
    #3;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    dec_valid = 0; dec_we = 0; dec_is_load = 0; dec_rd = '0;
    dec_rs = '0; dec_rs_used = '0; ext_stall = 0; flush = 0;
    idle();
    chk("rst_fwd_sel", 32'(fwd_sel), 0);
    chk("rst_hazard", 32'(hazard_stall), 0);
    chk("rst_retire", 32'(retire_valid), 0);
    chk("rst_count", 32'(stall_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back ALU forwarding
    cyc(1, 1, 0, 5, 0, 0, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 5, 0, 2'b01, 0, 0);
    chk("alu_sel1", 32'(fwd_sel[1:0]), 1);
    chk("alu_haz", 32'(hazard_stall), 0);
    cyc(1, 0, 0, 0, 5, 0, 2'b01, 0, 0);
    chk("alu_sel2", 32'(fwd_sel[1:0]), 2);
    idle();
    chk("alu_retire", 32'(retire_valid), 1);
    chk("alu_retire_rd", 32'(retire_rd), 5);

    // load-use: one bubble then stage-2 forward
    cyc(1, 1, 1, 7, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 0, 8, 0, 7, 2'b10, 0, 0);
    chk("lu_haz", 32'(hazard_stall), 1);
    chk("lu_sel_stall", 32'(fwd_sel[3:2]), 0);
    cyc(1, 1, 0, 8, 0, 7, 2'b10, 0, 0);
    chk("lu_haz_clr", 32'(hazard_stall), 0);
    chk("lu_sel", 32'(fwd_sel[3:2]), 2);
    chk("lu_count", 32'(stall_count), 1);

    // x0 writer and unused sources never forward
    cyc(1, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 1, 4, 0, 0, 2'b11, 0, 0);
    chk("x0_sel", 32'(fwd_sel), 0);
    cyc(1, 0, 0, 0, 4, 4, 2'b00, 0, 0);
    chk("unused_sel", 32'(fwd_sel), 0);
    chk("unused_haz", 32'(hazard_stall), 0);

    // youngest of two matching writers wins
    cyc(1, 1, 0, 3, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 0, 3, 0, 0, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 3, 0, 2'b01, 0, 0);
    chk("young_sel", 32'(fwd_sel[1:0]), 1);

    // flush kills a pending load and suppresses the stall
    cyc(1, 1, 1, 9, 0, 0, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 9, 0, 2'b01, 0, 1);
    chk("fl_haz", 32'(hazard_stall), 0);
    cyc(1, 0, 0, 0, 9, 0, 2'b01, 0, 0);
    chk("fl_sel", 32'(fwd_sel[1:0]), 0);
    chk("fl_haz2", 32'(hazard_stall), 0);
    idle();
    chk("fl_no_retire", 32'(retire_valid), 0);

    // ext_stall freezes a pending load-use
    cyc(1, 1, 1, 7, 0, 0, 2'b00, 0, 0);
    for (int n = 0; n < 4; n++) begin
      cyc(1, 0, 0, 0, 7, 0, 2'b01, 1, 0);
      chk("es_haz", 32'(hazard_stall), 1);
      chk("es_count", 32'(stall_count), 1);
    end
    cyc(1, 0, 0, 0, 7, 0, 2'b01, 0, 0);
    chk("es_haz_rel", 32'(hazard_stall), 1);
    cyc(1, 0, 0, 0, 7, 0, 2'b01, 0, 0);
    chk("es_sel", 32'(fwd_sel[1:0]), 2);
    chk("es_count2", 32'(stall_count), 2);

    // asynchronous reset mid-sequence
    cyc(1, 1, 0, 7, 7, 7, 2'b11, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_sel", 32'(fwd_sel), 0);
    chk("ar_haz", 32'(hazard_stall), 0);
    chk("ar_retire", 32'(retire_valid), 0);
    chk("ar_retire_rd", 32'(retire_rd), 0);
    chk("ar_count", 32'(stall_count), 0);
    idle();
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic on a small register set to force overlaps
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      dec_valid   = ($urandom_range(0, 9) < 8);
      dec_we      = ($urandom_range(0, 9) < 7);
      dec_is_load = ($urandom_range(0, 9) < 4);
      dec_rd      = RA_W'($urandom_range(0, 3));
      dec_rs      = {RA_W'($urandom_range(0, 3)), RA_W'($urandom_range(0, 3))};
      dec_rs_used = NRS'($urandom_range(0, 3));
      ext_stall   = ($urandom_range(0, 99) < 15);
      flush       = ($urandom_range(0, 99) < 10);
      if (n % 700 == 699) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised forwarding and interlock unit for the Riscv151 pipeline family.
- Tracks in-flight register writes across DEPTH post-decode stages.
- Every cycle it picks the forwarding source for each decode read port, raises a load-use interlock when a source is not yet ready, and kills younger entries on a redirect.
- Sits beside control and generalises its fixed two-stage bypass/bypass-delay logic to arbitrary depth, read-port count and per-class data latency.

Parameters:
- DEPTH, 3, number of post-decode stages holding in-flight writes (stage 1 = X, stage DEPTH = writeback); minimum 2.
- NRS, 2, number of decode read ports.
- RA_W, 5, register index width.
- ALU_AVAIL, 1, first stage whose ALU/CSR/PC+4 result can be forwarded.
- LOAD_AVAIL, 2, first stage whose load data can be forwarded; constraint ALU_AVAIL <= LOAD_AVAIL <= DEPTH.
- KILL_DEPTH, 1, number of youngest stages cleared by flush (0..DEPTH-1).
- CNT_W, 16, width of the interlock-cycle counter.
- SEL_W, derived as clog2(DEPTH+1), forwarding select width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode slot holds a live instruction.
- dec_we  in  1  decode instruction writes rd.
- dec_is_load  in  1  decode instruction is a load.
- dec_rd  in  RA_W  destination register.
- dec_rs  in  NRS*RA_W  source registers, port i at bits [i*RA_W +: RA_W].
- dec_rs_used  in  NRS  per-port source-used flag.
- ext_stall  in  1  cache/memory stall; freezes the whole pipeline.
- flush  in  1  redirect (taken branch/jump) resolved this cycle.
- fwd_sel  out  NRS*SEL_W  per-port source: 0 = regfile, k = stage k result.
- hazard_stall  out  1  load-use interlock; decode and fetch must hold.
- retire_valid  out  1  stage-DEPTH entry is valid and writes.
- retire_rd  out  RA_W  rd of the stage-DEPTH entry.
- stall_count  out  CNT_W  saturating count of hazard_stall cycles.

Behaviour:
- State: entry[1..DEPTH], each holding {v, we, ld, rd}. Reset (reset low, asynchronous) clears every v, we, ld and rd to 0 and clears stall_count to 0.
- Outputs during reset: fwd_sel 0, hazard_stall 0, retire_valid 0, retire_rd 0.
- Match: stage k matches port i when all of the following hold: entry[k].v, entry[k].we, entry[k].rd == rs_i, rs_i != 0, dec_rs_used[i], dec_valid.
- Priority: the youngest (lowest k) match wins; no match selects fwd_sel = 0.
- Readiness: a winning stage k is ready when k >= (ld ? LOAD_AVAIL : ALU_AVAIL).
- Select value: ready winner gives fwd_sel_i = k. Unready winner gives fwd_sel_i = 0 and asserts hazard_stall. Older matching stages are never used when a younger one matches.
- hazard_stall is the combinational OR over ports, gated to 0 when flush = 1. It is independent of ext_stall.
- Advance, on the rising edge when ext_stall = 0:
  - entry[k+1] <= entry[k] for k = 1..DEPTH-1.
  - entry[1] <= decode entry if dec_valid & ~hazard_stall & ~flush, else a bubble (v = 0).
  - entry[DEPTH] drops off.
- ext_stall = 1: no shift; all entries hold.
- flush = 1: entries 1..KILL_DEPTH get v <= 0 and the decode entry is not inserted. The rest shift normally, or hold if ext_stall. A flush under ext_stall still kills; the kill is applied in place.
- retire_valid = entry[DEPTH].v & entry[DEPTH].we; retire_rd = entry[DEPTH].rd. These are registered state, so they have no combinational path from inputs.
- stall_count increments by 1 on each edge where hazard_stall = 1 and ext_stall = 0, and saturates at all-ones (no wrap).
- Simultaneous events:
  - flush with a would-be hazard: flush wins; no stall, no insert.
  - ext_stall with hazard: hazard_stall is still reported, nothing moves and the counter holds.
- Load-use with default parameters: one bubble. The consumer sees fwd_sel = 2 on the next cycle.

Test Plan:
- Back-to-back ALU: add x5 then use of x5 on port 0 in the next cycle -> fwd_sel[0] = 1, hazard_stall = 0; one cycle later (no intervening write) the still-matching older entry gives fwd_sel = 2.
- Load-use: lw x7 then add using x7 on port 1 -> hazard_stall = 1 for exactly 1 cycle with a bubble in stage 1; next cycle fwd_sel[1] = 2 and stall_count = 1.
- x0 / unused source: writer with rd = 0, or dec_rs_used = 0 -> fwd_sel = 0, hazard_stall = 0 in all cycles.
- Youngest priority: x3 written in stages 1 and 2 simultaneously, consumer reads x3 -> fwd_sel = 1.
- Flush: load x9 in stage 1 with flush = 1 and a consumer of x9 at decode -> hazard_stall = 0; after the edge entry[1].v = 0; x9 never reaches retire_valid.
- ext_stall and reset: hold ext_stall 4 cycles with a load-use pending -> entries frozen, stall_count unchanged, hazard_stall stays 1. Then assert reset mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
